// File: rtl/chip_pkg.sv
// Shared sizing constants and load-state encoding for the weight load path.
package chip_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CNN_WORDS = 50704;
  localparam int unsigned FC_WORDS  = 11218;
  localparam int unsigned CNN_AW    = 16;
  localparam int unsigned FC_AW     = 14;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_CNN,
    LOAD_FC,
    DONE
  } load_state_t;

endpackage

// File: rtl/load_counter.sv
// Word counter for one weight stream; saturates at LAST so it never wraps within a load.
module load_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LAST  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             is_last
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !is_last) begin
      count <= count + WIDTH'(1);
    end
  end

  assign is_last = (count == LAST_V);

endmodule

// File: rtl/weight_loader.sv
// Streams CNN then FC weight words into their RAMs, one write per accepted word.
module weight_loader #(
  parameter int unsigned DATA_W    = chip_pkg::DATA_W,
  parameter int unsigned CNN_WORDS = chip_pkg::CNN_WORDS,
  parameter int unsigned FC_WORDS  = chip_pkg::FC_WORDS,
  parameter int unsigned CNN_AW    = chip_pkg::CNN_AW,
  parameter int unsigned FC_AW     = chip_pkg::FC_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [DATA_W-1:0] cnn_word,
  input  logic              cnn_valid,
  output logic              cnn_ready,
  input  logic [DATA_W-1:0] fc_word,
  input  logic              fc_valid,
  output logic              fc_ready,
  output logic [CNN_AW-1:0] cnn_address,
  output logic [DATA_W-1:0] cnn_data_in,
  output logic              cnn_write_enable,
  output logic [FC_AW-1:0]  fc_address,
  output logic [DATA_W-1:0] fc_data_in,
  output logic              fc_write_enable,
  output logic              finish_cnn,
  output logic              finish_fc,
  output logic              done,
  output logic              busy
);
  import chip_pkg::*;

  load_state_t       state, state_next;
  logic              cnn_acc, fc_acc, start_load;
  logic              cnn_ready_d, fc_ready_d, busy_d;
  logic [CNN_AW-1:0] cnn_count;
  logic [FC_AW-1:0]  fc_count;
  logic              cnn_last, fc_last;

  assign cnn_acc    = cnn_valid & cnn_ready;
  assign fc_acc     = fc_valid & fc_ready;
  assign start_load = load_start & ((state == IDLE) | (state == DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (load_start)          state_next = LOAD_CNN;
      LOAD_CNN: if (cnn_acc && cnn_last) state_next = LOAD_FC;
      LOAD_FC:  if (fc_acc && fc_last)   state_next = DONE;
      DONE:     if (load_start)          state_next = LOAD_CNN;
      default:                           state_next = IDLE;
    endcase
  end

  // Readies and busy are decoded from the next state so the flops track the state exactly.
  always_comb begin
    cnn_ready_d = 1'b0;
    fc_ready_d  = 1'b0;
    busy_d      = 1'b0;
    unique case (state_next)
      LOAD_CNN: begin cnn_ready_d = 1'b1; busy_d = 1'b1; end
      LOAD_FC:  begin fc_ready_d  = 1'b1; busy_d = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnn_ready        <= 1'b0;
      fc_ready         <= 1'b0;
      busy             <= 1'b0;
      cnn_address      <= '0;
      cnn_data_in      <= '0;
      cnn_write_enable <= 1'b0;
      fc_address       <= '0;
      fc_data_in       <= '0;
      fc_write_enable  <= 1'b0;
      finish_cnn       <= 1'b0;
      finish_fc        <= 1'b0;
      done             <= 1'b0;
    end else begin
      cnn_ready        <= cnn_ready_d;
      fc_ready         <= fc_ready_d;
      busy             <= busy_d;
      cnn_write_enable <= cnn_acc;
      fc_write_enable  <= fc_acc;
      if (cnn_acc) begin
        cnn_address <= cnn_count;
        cnn_data_in <= cnn_word;
      end
      if (fc_acc) begin
        fc_address <= fc_count;
        fc_data_in <= fc_word;
      end
      // done follows one cycle into DONE; a reload clears all flags on the same edge.
      if (start_load) begin
        finish_cnn <= 1'b0;
        finish_fc  <= 1'b0;
        done       <= 1'b0;
      end else begin
        if (cnn_acc && cnn_last) finish_cnn <= 1'b1;
        if (fc_acc && fc_last)   finish_fc  <= 1'b1;
        if (state == DONE)       done       <= 1'b1;
      end
    end
  end

  load_counter #(
    .WIDTH (CNN_AW),
    .LAST  (CNN_WORDS - 1)
  ) u_cnn_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_load),
    .inc     (cnn_acc),
    .count   (cnn_count),
    .is_last (cnn_last)
  );

  load_counter #(
    .WIDTH (FC_AW),
    .LAST  (FC_WORDS - 1)
  ) u_fc_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_load),
    .inc     (fc_acc),
    .count   (fc_count),
    .is_last (fc_last)
  );

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Sequential load controller between the I/O front end and the two weight RAMs (CNN memory, FC memory).
- On a start pulse it accepts a 16-bit CNN weight word stream, then an FC weight word stream, over valid/ready handshakes.
- Each accepted word is written to the matching RAM at an auto-incrementing address.
- It reports per-memory finish flags and an overall done flag to the chip top, which gates the compute stages.

Parameters:
- DATA_W, 16, weight word width
- CNN_WORDS, 50704, number of words written to CNN memory
- FC_WORDS, 11218, number of words written to FC memory
- CNN_AW, 16, CNN memory address width
- FC_AW, 14, FC memory address width

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- load_start  input  1  single-cycle start pulse
- cnn_word  input  DATA_W  CNN weight word from I/O
- cnn_valid  input  1  cnn_word valid
- cnn_ready  output  1  loader accepts cnn_word this cycle
- fc_word  input  DATA_W  FC weight word from I/O
- fc_valid  input  1  fc_word valid
- fc_ready  output  1  loader accepts fc_word this cycle
- cnn_address  output  CNN_AW  CNN memory write address
- cnn_data_in  output  DATA_W  CNN memory write data
- cnn_write_enable  output  1  CNN memory write strobe
- fc_address  output  FC_AW  FC memory write address
- fc_data_in  output  DATA_W  FC memory write data
- fc_write_enable  output  1  FC memory write strobe
- finish_cnn  output  1  all CNN words written
- finish_fc  output  1  all FC words written
- done  output  1  both memories loaded
- busy  output  1  load in progress

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; both counters go to 0.
  - All outputs go to 0, including addresses, data, write enables, readies and flags.
  - Reset mid-load aborts the load. Already-written RAM contents are not cleared.
- FSM states: IDLE, LOAD_CNN, LOAD_FC, DONE.
  - IDLE -> LOAD_CNN on load_start.
  - LOAD_CNN -> LOAD_FC on accepting CNN word CNN_WORDS-1.
  - LOAD_FC -> DONE on accepting FC word FC_WORDS-1.
  - DONE -> LOAD_CNN on load_start (reload). This clears all three flags and both counters in the same cycle.
- Readiness:
  - cnn_ready = 1 only in LOAD_CNN; fc_ready = 1 only in LOAD_FC.
  - Both are registered outputs. Neither depends combinationally on its valid input.
  - A stream's valid is ignored in any state where that stream's ready is 0. No word is consumed.
- Accept: valid & ready at a clk edge.
- Write latency 1 cycle after an accept:
  - *_write_enable is 1 for exactly one cycle.
  - *_address = counter value at accept (0-based); *_data_in = accepted word.
- Write enable while idle: when no accept occurs, write enable = 0. Address and data hold their last values.
- Counters:
  - Increment by 1 per accept and never wrap within a load.
  - Terminal compare is against N-1. No word beyond N-1 is ever written.
- Flag timing:
  - finish_cnn rises in the same cycle as the write of CNN word CNN_WORDS-1. It is sticky until reset or reload.
  - finish_fc rises in the same cycle as the write of FC word FC_WORDS-1. It is sticky until reset or reload.
  - done rises one cycle after finish_fc rises (state DONE). It is sticky.
  - busy = 1 in LOAD_CNN and LOAD_FC.
- load_start while busy is ignored.
- Back-pressure-free throughput: 1 word/cycle with valid held high.
  - Minimum total load time = CNN_WORDS + FC_WORDS + 2 cycles from the start pulse to done.
- Stall: a valid gap does not advance the counter and produces no write.

Decomposition:
- Package chip_pkg holds:
  - DATA_W, CNN_WORDS, FC_WORDS, CNN_AW, FC_AW;
  - the load-state enum (IDLE, LOAD_CNN, LOAD_FC, DONE).
- One sub-module, load_counter (parameters WIDTH, LAST):
  - inputs clk, rst_n, clr, inc; outputs count and is_last;
  - instantiated twice, once for CNN and once for FC.

Test Plan:
- Reset mid-load: 3 CNN words accepted, then rst_n=0 for 1 cycle -> all outputs 0, state IDLE; next load_start restarts at cnn_address 0.
- Small config, full stream: CNN_WORDS=4, FC_WORDS=3; pulse load_start, then continuous valid, words 0x1000..0x1003 and 0x2000..0x2002 ->
  - CNN writes at addresses 0..3 with matching data, finish_cnn high with the address-3 write;
  - FC writes at addresses 0..2 with matching data, finish_fc high with the address-2 write;
  - done one cycle later; total 9 cycles from start to done.
- Gapped valid: toggle cnn_valid 1,0,1,0 -> a write only one cycle after each accept, addresses contiguous 0,1; no write in gap cycles.
- Ignore rules:
  - fc_valid=1 during LOAD_CNN -> fc_ready=0 and no FC write;
  - load_start during LOAD_FC -> no counter reset, load completes normally.
- Reload: load_start in DONE -> flags clear that cycle, counters back to 0, second pass rewrites from address 0.
- Default parameters: 50704 + 11218 words with continuous valid -> last CNN address 50703, last FC address 11217, done at cycle 61924 after start.
